// File: rtl/ma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ma_pkg
// Purpose  : Shared types and constants for the MA stage with store buffer.
//            This file holds the load/store size codes, the IO address tag,
//            the store-buffer entry layout and the store alignment helpers.
// Revision : 1.0  initial release
// ============================================================================
package ma_pkg;

    localparam logic [2:0] LDST_BYTE = 3'b000;
    localparam logic [2:0] LDST_HALF = 3'b001;
    localparam logic [2:0] LDST_WORD = 3'b010;

    // Addresses whose top two bits match this tag belong to IO space
    localparam logic [1:0] IO_TAG = 2'b11;

    // The full 30-bit word address is kept so that forwarding never aliases
    localparam int SB_ADR_W = 30;

    typedef struct packed {
        logic [SB_ADR_W-1:0] adr;
        logic [31:0]         data;
        logic [3:0]          be;
    } sb_entry_t;

    // Byte enables for a store of the given size at the given byte offset
    function automatic logic [3:0] st_be(input logic [2:0] code, input logic [1:0] ofs);
        logic [3:0] be;
        be = 4'b0000;
        case (code)
            LDST_BYTE: be = 4'b0001 << ofs;
            LDST_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
            LDST_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Moves the low bytes of the unaligned store data into their RAM lanes
    function automatic logic [31:0] st_align(input logic [2:0] code, input logic [1:0] ofs,
                                             input logic [31:0] data);
        logic [31:0] al;
        al = 32'h0;
        case (code)
            LDST_BYTE: al = {24'h0, data[7:0]} << {ofs, 3'b000};
            LDST_HALF: al = ofs[1] ? {data[15:0], 16'h0} : {16'h0, data[15:0]};
            LDST_WORD: al = data;
            default:   al = 32'h0;
        endcase
        return al;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ma_sb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ma_sb_fifo
// Purpose  : In-order store buffer storage: entry array, head/tail pointers,
//            occupancy count, full/empty flags and the per-byte-lane
//            youngest-match search used for store-to-load forwarding.
// Revision : 1.0  initial release
// ============================================================================
module ma_sb_fifo
    import ma_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int DWIDTH   = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  sb_entry_t           push_entry_i,
    input  logic                pop_i,
    input  logic [SB_ADR_W-1:0] lookup_adr_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [DWIDTH-1:0]   head_ram_adr_o,
    output logic [31:0]         head_data_o,
    output logic [3:0]          head_be_o,
    output logic [31:0]         fwd_data_o,
    output logic [3:0]          fwd_mask_o
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          mem_q [SB_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    assign full_o         = (count_q == CNT_W'(SB_DEPTH));
    assign empty_o        = (count_q == '0);
    assign head_ram_adr_o = mem_q[head_q].adr[DWIDTH-1:0];
    assign head_data_o    = mem_q[head_q].data;
    assign head_be_o      = mem_q[head_q].be;

    // Next pointer and count values; pointers wrap naturally at SB_DEPTH
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {{(CNT_W-1){1'b0}}, push_i} - {{(CNT_W-1){1'b0}}, pop_i};
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
    end

    // Pointer and count state; reset drops every buffered entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= push_entry_i;
    end

    // Walk entries oldest to youngest so a younger match overwrites an older one
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_data_o = '0;
        fwd_mask_o = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_q[idx].adr == lookup_adr_i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_q[idx].be[b]) begin
                        fwd_mask_o[b]        = 1'b1;
                        fwd_data_o[8*b +: 8] = mem_q[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ma_stage_sb.sv
`default_nettype none
// ============================================================================
// Module   : ma_stage_sb
// Purpose  : Memory-access pipeline stage with an in-order store buffer in
//            front of a single-port data RAM. Stores retire into the buffer,
//            drain in cycles without a load, and loads get byte-granular
//            forwarding from pending stores. Feeds the WB register set.
// Revision : 1.0  initial release
// ============================================================================
module ma_stage_sb
    import ma_pkg::*;
#(
    parameter int DWIDTH   = 14,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_ld_ma,
    input  logic              cmd_st_ma,
    input  logic              fence_ma,
    input  logic [2:0]        ldst_code_ma,
    input  logic [31:0]       rd_data_ma,
    input  logic [31:0]       st_data_ma,
    input  logic [4:0]        rd_adr_ma,
    input  logic              wbk_rd_reg_ma,
    input  logic              stall,
    input  logic              rst_pipe_ma,
    output logic              sb_stall,
    output logic              sb_empty,
    output logic [DWIDTH-1:0] ram_adr,
    output logic              ram_ren,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              cmd_ld_wb,
    output logic [2:0]        ld_code_wb,
    output logic [4:0]        rd_adr_wb,
    output logic [31:0]       rd_data_wb,
    output logic              wbk_rd_reg_wb,
    output logic [31:0]       ld_data_wb
);

    logic              w_is_io;
    logic              w_code_ok;
    logic              w_ld;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    sb_entry_t         w_push_entry;
    logic [DWIDTH-1:0] w_head_ram_adr;
    logic [31:0]       w_head_data;
    logic [3:0]        w_head_be;
    logic [31:0]       w_fwd_data;
    logic [3:0]        w_fwd_mask;

    logic              cmd_ld_wb_q, cmd_ld_wb_d;
    logic [2:0]        ld_code_wb_q, ld_code_wb_d;
    logic [4:0]        rd_adr_wb_q, rd_adr_wb_d;
    logic [31:0]       rd_data_wb_q, rd_data_wb_d;
    logic              wbk_rd_reg_wb_q, wbk_rd_reg_wb_d;
    logic              ld_ram_q, ld_ram_d;
    logic [31:0]       fwd_data_q, fwd_data_d;
    logic [3:0]        fwd_mask_q, fwd_mask_d;

    assign w_is_io   = (rd_data_ma[31:30] == IO_TAG);
    assign w_code_ok = (ldst_code_ma == LDST_BYTE) | (ldst_code_ma == LDST_HALF) |
                       (ldst_code_ma == LDST_WORD);
    assign w_ld      = cmd_ld_ma & ~w_is_io;
    assign w_push    = cmd_st_ma & ~stall & ~w_full & ~w_is_io & w_code_ok;
    // A load owns the RAM port; the buffer drains in every other cycle
    assign w_pop     = ~w_empty & ~w_ld;

    assign sb_stall  = (cmd_st_ma & ~w_is_io & w_full) | (fence_ma & ~w_empty);
    assign sb_empty  = w_empty;
    assign ram_ren   = w_ld;
    assign ram_wen   = w_pop ? w_head_be   : 4'b0000;
    assign ram_wdata = w_pop ? w_head_data : 32'h0;

    // Entry built from the store in MA: word address, lane-aligned data, enables
    always_comb begin
        w_push_entry      = '0;
        w_push_entry.adr  = rd_data_ma[31:2];
        w_push_entry.data = st_align(ldst_code_ma, rd_data_ma[1:0], st_data_ma);
        w_push_entry.be   = st_be(ldst_code_ma, rd_data_ma[1:0]);
    end

    // Shared RAM address: load address wins, otherwise the draining head entry
    always_comb begin
        ram_adr = '0;
        if (w_ld)       ram_adr = rd_data_ma[DWIDTH+1:2];
        else if (w_pop) ram_adr = w_head_ram_adr;
    end

    ma_sb_fifo #(
        .SB_DEPTH (SB_DEPTH),
        .DWIDTH   (DWIDTH)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_i         (w_push),
        .push_entry_i   (w_push_entry),
        .pop_i          (w_pop),
        .lookup_adr_i   (rd_data_ma[31:2]),
        .full_o         (w_full),
        .empty_o        (w_empty),
        .head_ram_adr_o (w_head_ram_adr),
        .head_data_o    (w_head_data),
        .head_be_o      (w_head_be),
        .fwd_data_o     (w_fwd_data),
        .fwd_mask_o     (w_fwd_mask)
    );

    // Next values of the WB register set; a flush zeroes every field
    always_comb begin
        cmd_ld_wb_d     = cmd_ld_ma;
        ld_code_wb_d    = ldst_code_ma;
        rd_adr_wb_d     = rd_adr_ma;
        rd_data_wb_d    = rd_data_ma;
        wbk_rd_reg_wb_d = wbk_rd_reg_ma & ~stall & ~sb_stall;
        ld_ram_d        = w_ld;
        fwd_data_d      = w_fwd_data;
        fwd_mask_d      = w_ld ? w_fwd_mask : 4'b0000;
        if (rst_pipe_ma) begin
            cmd_ld_wb_d     = 1'b0;
            ld_code_wb_d    = 3'b000;
            rd_adr_wb_d     = 5'd0;
            rd_data_wb_d    = 32'h0;
            wbk_rd_reg_wb_d = 1'b0;
            ld_ram_d        = 1'b0;
            fwd_mask_d      = 4'b0000;
        end
    end

    // WB register set plus the forwarding bytes captured alongside the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ld_wb_q     <= 1'b0;
            ld_code_wb_q    <= 3'b000;
            rd_adr_wb_q     <= 5'd0;
            rd_data_wb_q    <= 32'h0;
            wbk_rd_reg_wb_q <= 1'b0;
            ld_ram_q        <= 1'b0;
            fwd_data_q      <= 32'h0;
            fwd_mask_q      <= 4'b0000;
        end else begin
            cmd_ld_wb_q     <= cmd_ld_wb_d;
            ld_code_wb_q    <= ld_code_wb_d;
            rd_adr_wb_q     <= rd_adr_wb_d;
            rd_data_wb_q    <= rd_data_wb_d;
            wbk_rd_reg_wb_q <= wbk_rd_reg_wb_d;
            ld_ram_q        <= ld_ram_d;
            fwd_data_q      <= fwd_data_d;
            fwd_mask_q      <= fwd_mask_d;
        end
    end

    assign cmd_ld_wb     = cmd_ld_wb_q;
    assign ld_code_wb    = ld_code_wb_q;
    assign rd_adr_wb     = rd_adr_wb_q;
    assign rd_data_wb    = rd_data_wb_q;
    assign wbk_rd_reg_wb = wbk_rd_reg_wb_q;

    // Per-lane merge of forwarded bytes over the RAM word; zero unless a RAM load is in WB
    always_comb begin
        ld_data_wb = 32'h0;
        if (ld_ram_q) begin
            for (int b = 0; b < 4; b++) begin
                ld_data_wb[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : ram_rdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire
